// File: rtl/tri_vertex_feeder.sv
// Vertex feeder for the triangle engine: holds a small vertex table loaded by
// the host, bursts each triangle as nt/xi/yi when the engine is idle, and
// forwards the engine's pixel stream with per-triangle and run totals.
module tri_vertex_feeder #(
  parameter int unsigned NUM_TRI = 2,
  parameter int unsigned BUSY_TO = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld_en,
  input  logic [$clog2(3*NUM_TRI)-1:0] ld_addr,
  input  logic [5:0]                   ld_data,
  input  logic                         start,
  output logic                         nt,
  output logic [2:0]                   xi,
  output logic [2:0]                   yi,
  input  logic                         busy,
  input  logic                         po,
  input  logic [2:0]                   xo,
  input  logic [2:0]                   yo,
  output logic                         pix_valid,
  output logic [2:0]                   pix_x,
  output logic [2:0]                   pix_y,
  output logic [7:0]                   tri_idx,
  output logic [5:0]                   tri_pix,
  output logic [8:0]                   pix_cnt,
  output logic                         done,
  output logic                         to_err,
  output logic                         proto_err
);

  localparam int unsigned Depth   = 3 * NUM_TRI;
  localparam int unsigned AW      = $clog2(Depth);
  localparam logic [7:0]  LastTri = 8'(NUM_TRI - 1);

  typedef enum logic [3:0] {
    StIdle, StIssue, StSend1, StSend2, StSend3, StWaitRise, StWaitFall, StNext, StDone
  } state_e;

  state_e state_q, state_d;

  logic [5:0]    vtx_mem [Depth];
  logic [AW-1:0] base_addr, rd_addr;

  logic       nt_q, nt_d;
  logic [2:0] xi_q, xi_d, yi_q, yi_d;
  logic       done_q, done_d;
  logic       pix_valid_q, pix_valid_d;
  logic [2:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0] tri_idx_q, tri_idx_d;
  logic [5:0] tri_pix_q, tri_pix_d;
  logic [8:0] pix_cnt_q, pix_cnt_d;
  logic       to_err_q, to_err_d;
  logic       proto_err_q, proto_err_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       idle_like, start_run, capture, timeout;

  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign start_run = idle_like && start;
  assign capture   = (state_q != StIdle);
  assign timeout   = (state_q == StWaitRise) && !busy && (to_cnt_q == 8'd1);
  assign base_addr = AW'(tri_idx_q) * AW'(3);

  // Vertex table: host writes only while no run is in flight; not reset.
  always_ff @(posedge clk) begin
    if (ld_en && idle_like) begin
      vtx_mem[ld_addr] <= ld_data;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StIssue;
      StIssue:        if (!busy) state_d = StSend1;
      StSend1:        state_d = StSend2;
      StSend2:        state_d = StSend3;
      StSend3:        state_d = StWaitRise;
      StWaitRise: begin
        if (busy)         state_d = StWaitFall;
        else if (timeout) state_d = StNext;
      end
      StWaitFall:     if (!busy) state_d = StNext;
      StNext:         state_d = (tri_idx_q == LastTri) ? StDone : StIssue;
      default:        state_d = StIdle;
    endcase
  end

  // Engine-facing outputs, computed from the state being entered so each is
  // stable for the whole state cycle.
  always_comb begin
    rd_addr = base_addr;
    if (state_d == StSend2)      rd_addr = base_addr + AW'(1);
    else if (state_d == StSend3) rd_addr = base_addr + AW'(2);
    nt_d   = (state_d == StSend1);
    done_d = (state_d == StDone);
    xi_d   = '0;
    yi_d   = '0;
    if (state_d inside {StSend1, StSend2, StSend3}) begin
      {xi_d, yi_d} = vtx_mem[rd_addr];
    end
  end

  // Pixel capture, counters, timeout and sticky error flags.
  always_comb begin
    pix_valid_d = pix_valid_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    tri_idx_d   = tri_idx_q;
    tri_pix_d   = tri_pix_q;
    pix_cnt_d   = pix_cnt_q;
    to_err_d    = to_err_q;
    proto_err_d = proto_err_q;
    to_cnt_d    = to_cnt_q;

    if (state_q == StIssue) tri_pix_d = '0;
    if (capture) begin
      pix_valid_d = po;
      pix_x_d     = xo;
      pix_y_d     = yo;
      if (po) begin
        tri_pix_d = tri_pix_d + 6'd1;
        if (pix_cnt_q != 9'h1FF) pix_cnt_d = pix_cnt_q + 9'd1;
      end
    end
    if (po && (state_q != StWaitRise) && (state_q != StWaitFall)) proto_err_d = 1'b1;

    if (state_q == StSend3) to_cnt_d = 8'(BUSY_TO);
    else if ((state_q == StWaitRise) && !busy) to_cnt_d = to_cnt_q - 8'd1;
    if (timeout) to_err_d = 1'b1;

    if ((state_q == StNext) && (tri_idx_q != LastTri)) tri_idx_d = tri_idx_q + 8'd1;

    // A new run wipes results, including a pixel landing on the start edge.
    if (start_run) begin
      tri_idx_d   = '0;
      tri_pix_d   = '0;
      pix_cnt_d   = '0;
      to_err_d    = 1'b0;
      proto_err_d = 1'b0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nt_q        <= 1'b0;
      xi_q        <= '0;
      yi_q        <= '0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      tri_idx_q   <= '0;
      tri_pix_q   <= '0;
      pix_cnt_q   <= '0;
      to_err_q    <= 1'b0;
      proto_err_q <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      nt_q        <= nt_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      done_q      <= done_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      tri_idx_q   <= tri_idx_d;
      tri_pix_q   <= tri_pix_d;
      pix_cnt_q   <= pix_cnt_d;
      to_err_q    <= to_err_d;
      proto_err_q <= proto_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign nt        = nt_q;
  assign xi        = xi_q;
  assign yi        = yi_q;
  assign done      = done_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign tri_idx   = tri_idx_q;
  assign tri_pix   = tri_pix_q;
  assign pix_cnt   = pix_cnt_q;
  assign to_err    = to_err_q;
  assign proto_err = proto_err_q;

endmodule

// File: doc/tri_vertex_feeder.md
# tri_vertex_feeder

Initiator side of the triangle rendering engine's vertex interface. Holds a small vertex table loaded by a host port, issues each triangle to the engine as a three-cycle `nt`/`xi`/`yi` burst whenever the engine's `busy` is low, then collects the engine's `po`/`xo`/`yo` pixel stream. Collected pixels are forwarded with per-triangle and total counts. Sits between the host/test controller and the `triangle` engine.

## Interface

- `NUM_TRI`, 2: triangles in the vertex table; table depth is `3*NUM_TRI` 6-bit entries.
- `BUSY_TO`, 16: cycles allowed in WAIT_RISE for `busy` to rise, range 1..255.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ld_en`  in  1  vertex table write strobe; honored only in IDLE or DONE.
- `ld_addr`  in  $clog2(3*NUM_TRI)  table entry; entry 3t+k is vertex k+1 of triangle t.
- `ld_data`  in  6  vertex: [5:3] x, [2:0] y.
- `start`  in  1  one-cycle pulse; begins a run from triangle 0; honored only in IDLE or DONE.
- `nt`  out  1  new-triangle strobe to the engine.
- `xi`, `yi`  out  3 each  vertex coordinates to the engine.
- `busy`  in  1  engine busy.
- `po`, `xo`, `yo`  in  1/3/3  engine pixel valid, x and y.
- `pix_valid`, `pix_x`, `pix_y`  out  1/3/3  registered copy of the pixel stream.
- `tri_idx`  out  8  index of the triangle currently issued or rendering.
- `tri_pix`  out  6  pixels collected for the current triangle.
- `pix_cnt`  out  9  total pixels in the run, saturating at 511.
- `done`  out  1  high while in DONE.
- `to_err`  out  1  sticky: a triangle hit the busy timeout.
- `proto_err`  out  1  sticky: `po` was seen outside WAIT_RISE/WAIT_FALL.

## Operation

- Reset values: state IDLE; all outputs 0. The vertex table is not reset. Reset mid-run aborts the run immediately; no further `nt` is issued.
- States:
  - IDLE: on `start`, go to ISSUE. Clears `tri_idx`, `tri_pix`, `pix_cnt`, `to_err` and `proto_err`.
  - ISSUE: if `busy`=0, go to SEND1; otherwise hold. Clears `tri_pix`.
  - SEND1: `nt`=1, `xi`/`yi` = entry 3t; go to SEND2.
  - SEND2: `nt`=0, `xi`/`yi` = entry 3t+1; go to SEND3.
  - SEND3: `xi`/`yi` = entry 3t+2; go to WAIT_RISE. Load the timeout counter with `BUSY_TO`.
  - WAIT_RISE: if `busy`=1, go to WAIT_FALL. Otherwise decrement the counter; on reaching 0, set `to_err` and go to NEXT.
  - WAIT_FALL: when `busy`=0, go to NEXT.
  - NEXT: if `tri_idx`=NUM_TRI-1, go to DONE; otherwise increment `tri_idx` and go to ISSUE.
  - DONE: `done`=1. `start` acts as it does in IDLE.
- Engine-facing outputs are registered and updated on entry to each state, so each value is stable for that whole state cycle. `xi`/`yi` are 0 in every state other than SEND1–SEND3.
- Pixel capture runs every cycle in every state except IDLE:
  - `pix_valid`, `pix_x`, `pix_y` are loaded from `po`, `xo`, `yo` (`pix_valid` ← `po`).
  - On `po`=1, `tri_pix` increments (wraps at 64) and `pix_cnt` increments (saturates at 511).
- `po`=1 outside WAIT_RISE/WAIT_FALL sets `proto_err`. That pixel is still captured and counted.
- If `po` and a state change fall on the same edge, the pixel is credited to the current `tri_idx`. `tri_pix` clears only in ISSUE.
- `ld_en` and `start` together in IDLE: the write and the start both take effect. Triangle 0 reads the table on the next cycle, so the new data is used.

## Timing

- Latency from `start` (sampled at edge N) with `busy`=0:
  - ISSUE at N+1.
  - `nt`=1 with vertex 1 during cycle N+2.
  - Vertex 2 during N+3, vertex 3 during N+4.
- Back-to-back triangles: the earliest next `nt` is 3 cycles after the edge at which `busy` is sampled 0 in WAIT_FALL (NEXT → ISSUE → SEND1).
- `pix_*` outputs lag the engine's `po` by one cycle.
- `done` rises one cycle after NEXT for the last triangle.
- Timeout: `to_err` is set `BUSY_TO` cycles after WAIT_RISE is entered.

## Test plan

- Table = {(1,0),(0,6),(6,6)}, `NUM_TRI`=1; behavioural engine raises `busy` 1 cycle after vertex 3, emits 10 pixels, then drops `busy`.
  - Expected: `nt` for exactly one cycle, vertices appear in order.
  - Expected: `tri_pix`=10, `pix_cnt`=10, `done`=1, both error flags 0.
- `NUM_TRI`=2 with triangles emitting 10 and 18 pixels.
  - Expected: second `nt` exactly 3 cycles after `busy` falls.
  - Expected: final `tri_idx`=1, `pix_cnt`=28.
- `busy`=1 when `start` arrives, held for 5 cycles.
  - Expected: FSM holds in ISSUE and `nt` stays 0 until `busy` falls.
- Engine never raises `busy`, `BUSY_TO`=4.
  - Expected: `to_err`=1 four cycles after SEND3; FSM advances; `done` is reached.
- Inject `po`=1 during SEND2.
  - Expected: `proto_err`=1; the pixel is still counted.
  - Then apply `start` from DONE. Expected: both flags and all counts clear.
- Assert `reset` mid-WAIT_FALL.
  - Expected: all outputs 0 immediately; IDLE; no `nt` until the next `start`.
